// File: rtl/cic_frame_sequencer.sv
// cic_frame_sequencer: shared decimation strobe plus channel-tagged readout of CIC snapshots.
// Optional CIC_FRAME_SEQ_FRAMECNT_EN adds an 8-bit out_frame tag per captured frame.
module cic_frame_sequencer #(
  parameter int N_CH      = 16,
  parameter int W         = 19,
  parameter int DEC_RATIO = 64,
  parameter int CAP_LAT   = 1,
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int DW = $clog2(DEC_RATIO)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [N_CH*W-1:0] ch_data,
  output logic              dec_clk,
  output logic [W-1:0]      out_data,
  output logic [CW-1:0]     out_ch,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              overrun
`ifdef CIC_FRAME_SEQ_FRAMECNT_EN
  ,
  output logic [7:0]        out_frame
`endif
);

  typedef enum logic {IDLE, SEND} state_t;

  logic [DW-1:0] dec_cnt_q, dec_cnt_d;
  logic          dec_clk_q, dec_clk_d;
  logic          cap;

  always_comb begin
    dec_cnt_d = dec_cnt_q;
    dec_clk_d = 1'b0;
    if (en) begin
      dec_cnt_d = (dec_cnt_q == DW'(DEC_RATIO-1))
                ? '0 : dec_cnt_q + DW'(1);
      dec_clk_d = (dec_cnt_q == DW'(DEC_RATIO-2));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dec_cnt_q <= '0;
      dec_clk_q <= 1'b0;
    end else begin
      dec_cnt_q <= dec_cnt_d;
      dec_clk_q <= dec_clk_d;
    end
  end

  // The delay line ignores en so a strobe already issued always captures.
  generate
    if (CAP_LAT == 0) begin : g_nolat
      assign cap = dec_clk_q;
    end else begin : g_lat
      logic [CAP_LAT-1:0] dly_q, dly_d;
      always_comb begin
        dly_d = (dly_q << 1) | CAP_LAT'(dec_clk_q);
      end
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) dly_q <= '0;
        else      dly_q <= dly_d;
      end
      assign cap = dly_q[CAP_LAT-1];
    end
  endgenerate

  state_t        state_q, state_d;
  logic [CW-1:0] ch_idx_q, ch_idx_d;
  logic          overrun_q, overrun_d;
  logic          hs, last, take;

  assign hs   = (state_q == SEND) && out_ready;
  assign last = (ch_idx_q == CW'(N_CH-1));

  always_comb begin
    state_d   = state_q;
    ch_idx_d  = ch_idx_q;
    overrun_d = overrun_q;
    take      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cap) begin
          take     = 1'b1;
          ch_idx_d = '0;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (hs && last) begin
          ch_idx_d = '0;
          if (cap) take = 1'b1;
          else     state_d = IDLE;
        end else begin
          if (hs)  ch_idx_d  = ch_idx_q + CW'(1);
          if (cap) overrun_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      ch_idx_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_idx_q  <= ch_idx_d;
      overrun_q <= overrun_d;
    end
  end

  logic [W-1:0] snap_q [N_CH];
  logic [W-1:0] snap_d [N_CH];

  always_comb begin
    snap_d = snap_q;
    if (take) begin
      for (int k = 0; k < N_CH; k++) begin
        snap_d[k] = ch_data[k*W +: W];
      end
    end
  end

  // Snapshot contents are only observable while SEND, so no reset.
  always_ff @(posedge clk) begin
    snap_q <= snap_d;
  end

  assign dec_clk   = dec_clk_q;
  assign out_valid = (state_q == SEND);
  assign out_data  = out_valid ? snap_q[ch_idx_q] : '0;
  assign out_ch    = ch_idx_q;
  assign out_last  = out_valid && last;
  assign overrun   = overrun_q;

`ifdef CIC_FRAME_SEQ_FRAMECNT_EN
  logic [7:0] fcnt_q, fcnt_d;
  logic [7:0] frame_q, frame_d;

  always_comb begin
    fcnt_d  = fcnt_q;
    frame_d = frame_q;
    if (take) begin
      frame_d = fcnt_q;
      fcnt_d  = fcnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fcnt_q  <= '0;
      frame_q <= '0;
    end else begin
      fcnt_q  <= fcnt_d;
      frame_q <= frame_d;
    end
  end

  assign out_frame = frame_q;
`endif

endmodule

// File: tb/tb_cic_frame_sequencer.sv
// Bench for cic_frame_sequencer: queue-based frame model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_cic_frame_sequencer;
  localparam int N_CH = 4;
  localparam int W    = 19;
  localparam int DR   = 8;
  localparam int CL   = 1;
  localparam int CW   = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              en = 1'b0;
  logic              out_ready = 1'b0;
  logic [N_CH*W-1:0] ch_data = '0;
  logic              dec_clk, out_valid, out_last, overrun;
  logic [W-1:0]      out_data;
  logic [CW-1:0]     out_ch;
`ifdef CIC_FRAME_SEQ_FRAMECNT_EN
  logic [7:0]        out_frame;
`endif

  int vec = 0;
  int err = 0;

  always #5 clk = ~clk;

  cic_frame_sequencer #(
    .N_CH(N_CH), .W(W), .DEC_RATIO(DR), .CAP_LAT(CL)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .ch_data(ch_data),
    .dec_clk(dec_clk), .out_data(out_data), .out_ch(out_ch),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .overrun(overrun)
`ifdef CIC_FRAME_SEQ_FRAMECNT_EN
    , .out_frame(out_frame)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [N_CH*W-1:0] rnd_data();
    logic [N_CH*W-1:0] r;
    for (int k = 0; k < N_CH; k++) r[k*W +: W] = W'($urandom);
    return r;
  endfunction

  // Model: a FIFO of pending words; a capture is accepted only when the
  // FIFO is empty after this cycle's handshake, otherwise it is dropped.
  typedef struct {
    logic [W-1:0] d;
    int           ch;
    int           fr;
  } word_t;

  word_t m_q[$];
  int    m_cnt;
  bit    m_hist[4];
  bit    m_ovr;
  int    m_fnext;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q.delete();
      m_cnt   = 0;
      m_ovr   = 0;
      m_fnext = 0;
      for (int i = 0; i < 4; i++) m_hist[i] = 0;
    end else begin
      bit cap_now;
      cap_now = m_hist[CL];
      if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
      if (cap_now) begin
        if (m_q.size() == 0) begin
          for (int k = 0; k < N_CH; k++) begin
            word_t w;
            w.d  = ch_data[k*W +: W];
            w.ch = k;
            w.fr = m_fnext;
            m_q.push_back(w);
          end
          m_fnext = (m_fnext + 1) % 256;
        end else begin
          m_ovr = 1;
        end
      end
      if (en) m_cnt = (m_cnt + 1) % DR;
      for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = en && (m_cnt == DR-1);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("dec_clk", dec_clk, m_hist[0]);
      chk("out_valid", out_valid, m_q.size() > 0);
      chk("overrun", overrun, m_ovr);
      if (m_q.size() > 0) begin
        chk("out_data", out_data, m_q[0].d);
        chk("out_ch", out_ch, m_q[0].ch);
        chk("out_last", out_last, m_q[0].ch == N_CH-1);
`ifdef CIC_FRAME_SEQ_FRAMECNT_EN
        chk("out_frame", out_frame, m_q[0].fr[7:0]);
`endif
      end else begin
        chk("out_last_idle", out_last, 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [W-1:0] lit[N_CH];
  logic [W-1:0] bpw[N_CH];

  initial begin
    int  first;
    int  nf;
    bit  found;
    lit = '{19'h00001, 19'h3FFFF, 19'h40000, 19'h7FFFF};
    bpw = '{19'h12345, 19'h0ABCD, 19'h55555, 19'h2AAAA};
    ch_data = {lit[3], lit[2], lit[1], lit[0]};

    repeat (3) @(negedge clk);
    chk("rst_dec_clk", dec_clk, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_data", out_data, 0);
    chk("rst_ch", out_ch, 0);
    chk("rst_overrun", overrun, 0);

    @(negedge clk);
    #2;
    rst = 1'b1;
    en = 1'b1;
    out_ready = 1'b1;
    // dec_cnt starts at 0, so the strobe lands on the 8th cycle.
    first = -1;
    for (int i = 1; i <= 20 && first < 0; i++) begin
      @(negedge clk);
      if (dec_clk) first = i;
    end
    chk("first_dec_clk", first, 7);

    @(negedge clk);
    chk("cap_cycle_valid", out_valid, 0);
    for (int k = 0; k < N_CH; k++) begin
      @(negedge clk);
      chk("f0_valid", out_valid, 1);
      chk("f0_ch", out_ch, k);
      chk("f0_data", out_data, lit[k]);
      chk("f0_last", out_last, k == N_CH-1);
      ch_data = rnd_data();
    end
    @(negedge clk);
    chk("f0_idle", out_valid, 0);

    ch_data = {bpw[3], bpw[2], bpw[1], bpw[0]};
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (m_q.size() == N_CH-1) found = 1;
    end
    chk("bp_sync", found, 1);
    if (found) begin
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("bp_hold_ch", out_ch, 1);
        chk("bp_hold_data", out_data, bpw[1]);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_resume_ch", out_ch, 2);
      chk("bp_resume_data", out_data, bpw[2]);
      @(negedge clk);
      chk("bp_next_data", out_data, bpw[3]);
      chk("bp_next_last", out_last, 1);
    end

    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      ch_data = rnd_data();
      if (m_q.size() == N_CH) found = 1;
    end
    chk("ovr_sync", found, 1);
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ch_data = rnd_data();
      chk("ovr_hold_ch", out_ch, 0);
    end
    chk("ovr_set", overrun, 1);

    // Hold the last word until a capture coincides with its handshake.
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_q.size() > 0 && m_q[0].ch == N_CH-1 && m_hist[CL]) found = 1;
      out_ready = (m_q.size() > 0 && m_q[0].ch != N_CH-1) || m_hist[CL];
      @(negedge clk);
      ch_data = rnd_data();
    end
    chk("align_found", found, 1);
    chk("b2b_valid", out_valid, 1);
    chk("b2b_ch", out_ch, 0);
    chk("b2b_overrun", overrun, 1);
    out_ready = 1'b1;

    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (m_cnt == 3) found = 1;
    end
    chk("en_sync", found, 1);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("en_off_dec_clk", dec_clk, 0);
    end
    en = 1'b1;
    first = -1;
    for (int i = 1; i <= 20 && first < 0; i++) begin
      @(negedge clk);
      if (dec_clk) first = i;
    end
    chk("en_resume_dec_clk", first, 4);

    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      ch_data = rnd_data();
      en = ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
    end

    en = 1'b1;
    out_ready = 1'b1;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (m_q.size() > 1) found = 1;
    end
    chk("rst_mid_sync", found, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_dec_clk", dec_clk, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_last", out_last, 0);
    chk("arst_data", out_data, 0);
    chk("arst_ch", out_ch, 0);
    chk("arst_overrun", overrun, 0);
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    first = -1;
    for (int i = 1; i <= 20 && first < 0; i++) begin
      @(negedge clk);
      ch_data = rnd_data();
      if (dec_clk) first = i;
    end
    chk("post_rst_dec_clk", first, 7);

    nf = 0;
    for (int i = 0; i < 40 && nf < 3; i++) begin
      @(negedge clk);
      ch_data = rnd_data();
      if (m_q.size() == N_CH) begin
`ifdef CIC_FRAME_SEQ_FRAMECNT_EN
        chk("frame_tag", out_frame, nf);
`endif
        chk("frame_start_ch", out_ch, 0);
        nf++;
      end
    end
    chk("frames_seen", nf, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
